// File: rtl/gift_perm_unit.sv
// gift_perm_unit
//
// This unit streams a GIFT state in over a narrow bus and applies the GIFT
// bit permutation, either forward or inverse. It then streams the result back
// out. The state is 64 bits (GIFT-64) or 128 bits (GIFT-128), and the width
// is chosen per block by the first input beat.
//
// Beat k of a block carries state bits [k*BUS_W +: BUS_W], with k = 0 first.
//
// Optional feature (macro GIFT_PERM_SBOX_EN):
//   - Forward mode becomes SubCells followed by the permutation.
//   - Inverse mode becomes the inverse permutation followed by inverse SubCells.
//   - The PERM phase takes two cycles instead of one.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort back to IDLE, discards any partial block
//   in_valid   input beat valid
//   in_ready   input beat accepted (IDLE/LOAD only)
//   in_data    input beat, BUS_W bits
//   wide       1 = 128-bit state, 0 = 64-bit state (sampled on first beat)
//   inv        1 = inverse, 0 = forward (sampled on first beat)
//   out_valid  output beat valid
//   out_ready  consumer accepts output beat
//   out_data   output beat, BUS_W bits
//   busy       FSM is not in IDLE
module gift_perm_unit #(
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             wide,
  input  logic             inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             busy
);

  localparam int MAXN = 128 / BUS_W;
  localparam int CW   = $clog2(MAXN);
  localparam logic [CW-1:0] LAST_W = CW'(MAXN - 1);
  localparam logic [CW-1:0] LAST_N = CW'(MAXN / 2 - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] PERM   = 2'd2;
  localparam logic [1:0] UNLOAD = 2'd3;

  logic [1:0]    fsm;
  logic [CW-1:0] icnt;
  logic [CW-1:0] ocnt;
  logic          wide_q;
  logic          inv_q;
  logic [127:0]  state_q;
  logic [CW-1:0] last_idx;
`ifdef GIFT_PERM_SBOX_EN
  logic          phase;
`endif

  // Bit i moves to P(i). In inverse mode the mapping is read the other way.
  // Both widths are built from constant loops, so no divider is inferred.
  // For the 64-bit case the upper half of the result is left at zero.
  function automatic logic [127:0] bit_perm(input logic [127:0] x,
                                            input logic w, input logic iv);
    logic [127:0] y64;
    logic [127:0] y128;
    logic [6:0]   s;
    logic [6:0]   d;
    int           p;
    y64  = '0;
    y128 = '0;
    for (int i = 0; i < 64; i++) begin
      p = 4 * (i / 16) + 16 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
      s = 7'(i);
      d = 7'(p);
      if (iv) y64[s] = x[d];
      else    y64[d] = x[s];
    end
    for (int i = 0; i < 128; i++) begin
      p = 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
      s = 7'(i);
      d = 7'(p);
      if (iv) y128[s] = x[d];
      else    y128[d] = x[s];
    end
    return w ? y128 : y64;
  endfunction

`ifdef GIFT_PERM_SBOX_EN
  function automatic logic [3:0] sbox4(input logic [3:0] n, input logic iv);
    logic [3:0] r;
    r = 4'h0;
    if (!iv) begin
      case (n)
        4'h0: r = 4'h1; 4'h1: r = 4'hA; 4'h2: r = 4'h4; 4'h3: r = 4'hC;
        4'h4: r = 4'h6; 4'h5: r = 4'hF; 4'h6: r = 4'h3; 4'h7: r = 4'h9;
        4'h8: r = 4'h2; 4'h9: r = 4'hD; 4'hA: r = 4'hB; 4'hB: r = 4'h7;
        4'hC: r = 4'h5; 4'hD: r = 4'h0; 4'hE: r = 4'h8; default: r = 4'hE;
      endcase
    end else begin
      case (n)
        4'h0: r = 4'hD; 4'h1: r = 4'h0; 4'h2: r = 4'h8; 4'h3: r = 4'h6;
        4'h4: r = 4'h2; 4'h5: r = 4'hC; 4'h6: r = 4'h4; 4'h7: r = 4'hB;
        4'h8: r = 4'hE; 4'h9: r = 4'h7; 4'hA: r = 4'h1; 4'hB: r = 4'hA;
        4'hC: r = 4'h3; 4'hD: r = 4'h9; 4'hE: r = 4'hF; default: r = 4'h5;
      endcase
    end
    return r;
  endfunction

  // The S-box is applied to all 32 nibbles. In 64-bit mode the upper
  // nibbles are never driven onto out_data, so their value does not matter.
  function automatic logic [127:0] sub_layer(input logic [127:0] x, input logic iv);
    logic [127:0] y;
    y = '0;
    for (int j = 0; j < 32; j++) y[4*j +: 4] = sbox4(x[4*j +: 4], iv);
    return y;
  endfunction
`endif

  function automatic logic [127:0] put_beat(input logic [127:0] x,
                                            input logic [CW-1:0] k,
                                            input logic [BUS_W-1:0] d);
    logic [127:0] y;
    y = x;
    for (int j = 0; j < MAXN; j++)
      if (CW'(j) == k) y[j*BUS_W +: BUS_W] = d;
    return y;
  endfunction

  function automatic logic [BUS_W-1:0] get_beat(input logic [127:0] x,
                                                input logic [CW-1:0] k);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int j = 0; j < MAXN; j++)
      if (CW'(j) == k) r = x[j*BUS_W +: BUS_W];
    return r;
  endfunction

  assign last_idx = wide_q ? LAST_W : LAST_N;
  assign in_ready = rst_n & ((fsm == IDLE) | (fsm == LOAD));
  assign busy     = (fsm != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      icnt      <= '0;
      ocnt      <= '0;
      wide_q    <= 1'b0;
      inv_q     <= 1'b0;
      state_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef GIFT_PERM_SBOX_EN
      phase     <= 1'b0;
`endif
    end else if (clr) begin
      fsm       <= IDLE;
      icnt      <= '0;
      ocnt      <= '0;
      out_valid <= 1'b0;
`ifdef GIFT_PERM_SBOX_EN
      phase     <= 1'b0;
`endif
    end else begin
      unique case (fsm)
        // Load stage: the first beat fixes the block geometry and direction.
        IDLE: begin
          if (in_valid) begin
            state_q <= put_beat(state_q, '0, in_data);
            wide_q  <= wide;
            inv_q   <= inv;
            icnt    <= CW'(1);
            fsm     <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            state_q <= put_beat(state_q, icnt, in_data);
            if (icnt == last_idx) begin
              icnt <= '0;
              fsm  <= PERM;
            end else begin
              icnt <= icnt + 1'b1;
            end
          end
        end
        // Permute stage: the whole state is transformed in place.
        PERM: begin
`ifdef GIFT_PERM_SBOX_EN
          if (!phase) begin
            state_q <= inv_q ? bit_perm(state_q, wide_q, 1'b1) : sub_layer(state_q, 1'b0);
            phase   <= 1'b1;
          end else begin
            state_q <= inv_q ? sub_layer(state_q, 1'b1) : bit_perm(state_q, wide_q, 1'b0);
            phase   <= 1'b0;
            fsm     <= UNLOAD;
          end
`else
          state_q <= bit_perm(state_q, wide_q, inv_q);
          fsm     <= UNLOAD;
`endif
        end
        // Unload stage: the first cycle only registers beat 0. After that,
        // each handshake preloads the next beat, so the stream has no bubbles.
        UNLOAD: begin
          if (!out_valid) begin
            out_data  <= get_beat(state_q, ocnt);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (ocnt == last_idx) begin
              out_valid <= 1'b0;
              ocnt      <= '0;
              fsm       <= IDLE;
            end else begin
              ocnt     <= ocnt + 1'b1;
              out_data <= get_beat(state_q, ocnt + 1'b1);
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
